// File: rtl/druaga_load_seq.sv
// druaga_load_seq: sequences ROM download and reset for the Druaga game core.
// Forwards index-0 download bytes to the core's ROM write port, captures the
// title number from index-1 writes, validates each ROM session, and holds the
// core in reset during loads, after user reset requests, and after failures.
//
// Ports
//   clk_sys        : system clock (single clock domain)
//   RESET          : asynchronous active-high reset
//   ioctl_download : download session active
//   ioctl_wr       : single-cycle byte write strobe
//   ioctl_addr     : byte address within the session
//   ioctl_dout     : write data
//   ioctl_index    : download target (0 = ROM image, 1 = title number)
//   rst_req        : user reset request, level
//   ROMAD/ROMDT    : registered ROM write address / data to the core
//   ROMEN          : registered one-cycle ROM write enable
//   tno            : captured title number
//   core_rst       : game core reset, active-high
//   rom_valid      : a complete ROM image is loaded
//   load_err       : last ROM session failed (sticky until next ROM session)
module druaga_load_seq #(
   parameter logic [24:0] ROM_SIZE    = 25'h20000,
   parameter logic [15:0] HOLD_CYCLES = 16'd4800
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   input  logic        rst_req,
   output logic [24:0] ROMAD,
   output logic [7:0]  ROMDT,
   output logic        ROMEN,
   output logic [3:0]  tno,
   output logic        core_rst,
   output logic        rom_valid,
   output logic        load_err
);

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, HOLD, ERROR} state_t;

   state_t      state;
   logic        dl_q;
   logic [24:0] byte_cnt;
   logic [24:0] exp_addr;
   logic        saw_rom;
   logic        ovf;
   logic        gap;
   logic [15:0] hold_cnt;

   logic dl_rise;
   logic dl_fall;
   logic wr_rom;
   logic wr_tno;

   assign dl_rise = ioctl_download & ~dl_q;
   assign dl_fall = ~ioctl_download & dl_q;
   assign wr_rom  = ioctl_wr && (ioctl_index == 8'd0);
   assign wr_tno  = ioctl_wr && (ioctl_index == 8'd1);

   // Sequencer: a download rising edge preempts every state, including HOLD
   // expiry and rst_req handling in the same cycle.
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state     <= HOLD;
         dl_q      <= 1'b0;
         byte_cnt  <= '0;
         exp_addr  <= '0;
         saw_rom   <= 1'b0;
         ovf       <= 1'b0;
         gap       <= 1'b0;
         hold_cnt  <= HOLD_CYCLES;
         ROMAD     <= '0;
         ROMDT     <= '0;
         ROMEN     <= 1'b0;
         tno       <= '0;
         core_rst  <= 1'b1;
         rom_valid <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         dl_q  <= ioctl_download;
         ROMEN <= 1'b0;
         if (dl_rise) begin
            state    <= LOAD;
            byte_cnt <= '0;
            exp_addr <= '0;
            saw_rom  <= 1'b0;
            ovf      <= 1'b0;
            gap      <= 1'b0;
            core_rst <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (rst_req) begin
                     state    <= HOLD;
                     hold_cnt <= HOLD_CYCLES;
                     core_rst <= 1'b1;
                  end
               end
               LOAD: begin
                  if (wr_rom) begin
                     // Any out-of-order address marks the image as gapped.
                     if (ioctl_addr != exp_addr) gap <= 1'b1;
                     if (ioctl_addr < ROM_SIZE) begin
                        ROMAD    <= ioctl_addr;
                        ROMDT    <= ioctl_dout;
                        ROMEN    <= 1'b1;
                        saw_rom  <= 1'b1;
                        exp_addr <= exp_addr + 25'd1;
                        if (byte_cnt != '1) byte_cnt <= byte_cnt + 25'd1;
                     end else begin
                        ovf <= 1'b1;
                     end
                  end else if (wr_tno) begin
                     tno <= ioctl_dout[3:0];
                  end
                  if (dl_fall) state <= CHECK;
               end
               CHECK: begin
                  hold_cnt <= HOLD_CYCLES;
                  if (saw_rom) begin
                     if ((byte_cnt == ROM_SIZE) && !ovf && !gap) begin
                        rom_valid <= 1'b1;
                        load_err  <= 1'b0;
                        state     <= HOLD;
                     end else begin
                        rom_valid <= 1'b0;
                        load_err  <= 1'b1;
                        state     <= ERROR;
                     end
                  end else begin
                     // Title-only session: image status carries over.
                     state <= rom_valid ? HOLD : ERROR;
                  end
               end
               HOLD: begin
                  // Release after HOLD_CYCLES cycles; zero behaves like one.
                  if (rst_req) begin
                     hold_cnt <= HOLD_CYCLES;
                  end else if (hold_cnt <= 16'd1) begin
                     core_rst <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     hold_cnt <= hold_cnt - 16'd1;
                  end
               end
               ERROR: begin
                  core_rst <= 1'b1;
               end
               default: begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_CYCLES;
                  core_rst <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/druaga_load_seq.md
DRUAGA_LOAD_SEQ -- requirements
Module: druaga_load_seq

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 25'h20000, meaning the exact byte count of a valid index-0 ROM image.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16'd4800, meaning the number of clk_sys cycles core reset is held after load or reset request.
REQ-003 SHALL have port clk_sys  input  1  system clock (48 MHz); the block uses one clock only.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port ioctl_download  input  1  download session active.
REQ-006 SHALL have port ioctl_wr  input  1  single-cycle byte write strobe.
REQ-007 SHALL have port ioctl_addr  input  25  byte address within the session.
REQ-008 SHALL have port ioctl_dout  input  8  write data.
REQ-009 SHALL have port ioctl_index  input  8  target (0 = ROM image, 1 = title number).
REQ-010 SHALL have port rst_req  input  1  user reset request (menu or button), level.
REQ-011 SHALL have port ROMAD  output  25  registered ROM write address to the game core.
REQ-012 SHALL have port ROMDT  output  8  registered ROM write data.
REQ-013 SHALL have port ROMEN  output  1  registered one-cycle ROM write enable.
REQ-014 SHALL have port tno  output  4  captured title number.
REQ-015 SHALL have port core_rst  output  1  game core reset, active-high.
REQ-016 SHALL have port rom_valid  output  1  a complete ROM image is loaded.
REQ-017 SHALL have port load_err  output  1  last ROM session failed (sticky until the next ROM session).

Function
REQ-018 SHALL implement states IDLE, LOAD, CHECK, HOLD, ERROR.
REQ-019 SHALL detect the ioctl_download rising edge with a registered copy and enter LOAD from any state.
REQ-020 SHALL, on LOAD entry, clear the byte counter, expected-address register, saw_rom flag and overflow flag, and assert core_rst.
REQ-021 SHALL, in LOAD, for ioctl_wr with index 0 and ioctl_addr < ROM_SIZE, drive ROMAD/ROMDT from ioctl_addr/ioctl_dout and pulse ROMEN one cycle later, for a latency of exactly 1 cycle.
REQ-022 SHALL count each accepted index-0 write (counter width 25 bits, saturating), set saw_rom, and increment the expected address.
REQ-023 SHALL drop index-0 writes with ioctl_addr >= ROM_SIZE (no ROMEN) and set the overflow flag.
REQ-024 SHALL set a gap flag when an index-0 write address differs from the expected address (first expected = 0).
REQ-025 SHALL, for ioctl_wr with index 1, load tno from ioctl_dout[3:0] with no ROMEN pulse; the last such write wins.
REQ-026 SHALL ignore writes with any other index, and any ioctl_wr outside LOAD.
REQ-027 SHALL, on the ioctl_download falling edge, go LOAD -> CHECK for one cycle.
REQ-028 SHALL, in CHECK with saw_rom=1: if count == ROM_SIZE and no overflow or gap, set rom_valid=1 and load_err=0 and go to HOLD; otherwise set rom_valid=0 and load_err=1 and go to ERROR.
REQ-029 SHALL, in CHECK with saw_rom=0 (an index-1-only session), leave rom_valid and load_err unchanged and go to HOLD if rom_valid=1, else to ERROR.
REQ-030 SHALL, in HOLD, keep core_rst=1, count HOLD_CYCLES cycles, then deassert core_rst and enter IDLE.
REQ-031 SHALL, in IDLE, on rst_req=1, assert core_rst and enter HOLD with the counter reloaded.
REQ-032 SHALL, in HOLD, while rst_req=1, reload the counter, so that release occurs HOLD_CYCLES after rst_req falls.
REQ-033 SHALL, in ERROR, hold core_rst=1 regardless of rst_req, and leave only on a download rising edge.
REQ-034 SHALL ignore rst_req in LOAD and CHECK.
REQ-035 SHALL give the download rising edge priority over the HOLD counter expiry and over rst_req when they occur in the same cycle.
REQ-036 SHALL, if HOLD_CYCLES = 0, release core_rst on the cycle after HOLD entry.

Reset
REQ-037 SHALL, while RESET=1, force state=HOLD, counter=HOLD_CYCLES, core_rst=1, ROMEN=0, ROMAD=0, ROMDT=0, tno=0, rom_valid=0, load_err=0.
REQ-038 SHALL, after RESET falls, release core_rst after HOLD_CYCLES cycles even though rom_valid=0, so that a core with no ROM image runs.
REQ-039 SHALL, on RESET asserted mid-LOAD, abandon the session, and the next download rising edge SHALL restart it cleanly.

Verification
REQ-040 Bench SHALL cover: ROM_SIZE=16, HOLD_CYCLES=8, 16 sequential index-0 writes -> 16 ROMEN pulses each 1 cycle late, rom_valid=1, core_rst falls 8 cycles after CHECK.
REQ-041 Bench SHALL cover: 15 writes, then download falls -> load_err=1, rom_valid=0, core_rst held; rst_req pulse -> core_rst stays 1.
REQ-042 Bench SHALL cover: write at addr 16 -> no ROMEN, load_err=1; write addresses 0,1,3 -> gap, load_err=1.
REQ-043 Bench SHALL cover: index-1 session writing 8'h03 after a valid ROM -> tno=3, rom_valid stays 1, core_rst pulses for 8 cycles.
REQ-044 Bench SHALL cover: rst_req held 20 cycles in IDLE -> core_rst=1 throughout and for 8 cycles after rst_req falls.
REQ-045 Bench SHALL cover: RESET asserted mid-LOAD, then a new full session -> all outputs at reset values, then rom_valid=1.
